// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register offsets, FSM encoding
// and the CAUSE word layout.
package irq_pkg;

    localparam logic [31:0] MASK_OFS  = 32'd0;
    localparam logic [31:0] PEND_OFS  = 32'd4;
    localparam logic [31:0] CAUSE_OFS = 32'd8;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ASSERT  = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    localparam int CAUSE_VALID_BIT = 31;

    function automatic logic [31:0] causeWord(input logic valid, input logic [2:0] idx);
        logic [31:0] w;
        w = 32'd0;
        w[CAUSE_VALID_BIT] = valid;
        w[2:0] = idx;
        return w;
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Peripheral bus slice seen by the interrupt controller: address, write data,
// strobes and combinational read data.
interface irq_controller_if;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mem_write;
    logic        mem_read;

    modport master (output addr, output wdata, output mem_write, output mem_read, input rdata);
    modport slave  (input addr, input wdata, input mem_write, input mem_read, output rdata);

endinterface

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index priority encoder over the active request vector.
module irq_prio_enc #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               any,
    output logic [2:0]         idx
);

    // scan from the top down so the smallest set index is the last one written
    always_comb begin
        idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = req[i] ? 3'(i) : idx;
        end
        any = |req;
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-latched requests, software mask, lowest-index pick
// and a one-at-a-time ack/done handshake with the core.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_SRC   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h40000030
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               kernel_mode,
    input  logic               irq_ack,
    input  logic               irq_done,
    irq_controller_if.slave    bus,
    output logic               IRQ
);

    logic [NUM_SRC-1:0] srcPrev_r;
    logic [NUM_SRC-1:0] mask_r;
    logic [NUM_SRC-1:0] pend_r;
    logic [1:0]         state_r;
    logic               causeValid_r;
    logic [2:0]         causeIdx_r;
    logic               irq_r;

    logic [NUM_SRC-1:0] edge_s;
    logic [NUM_SRC-1:0] active_s;
    logic [NUM_SRC-1:0] selOneHot_s;
    logic [NUM_SRC-1:0] pendClr_s;
    logic [NUM_SRC-1:0] pendNext_s;
    logic               any_s;
    logic [2:0]         sel_s;
    logic               maskWe_s;
    logic               pendWe_s;
    logic               ackTaken_s;
    logic [1:0]         stateNext_s;
    logic [31:0]        rdata_s;
    logic               unusedWdata_s;

    assign edge_s        = src_irq & ~srcPrev_r;
    assign active_s      = pend_r & mask_r;
    assign maskWe_s      = bus.mem_write && (bus.addr == (BASE_ADDR + MASK_OFS));
    assign pendWe_s      = bus.mem_write && (bus.addr == (BASE_ADDR + PEND_OFS));
    assign unusedWdata_s = ^bus.wdata;

    irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
        .req (active_s),
        .any (any_s),
        .idx (sel_s)
    );

    // state transition; ack outranks a same-cycle loss of the request
    always_comb begin
        stateNext_s = state_r;
        ackTaken_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_s && !kernel_mode) stateNext_s = ASSERT;
                else                       stateNext_s = IDLE;
            end
            ASSERT: begin
                if (irq_ack) begin
                    ackTaken_s  = 1'b1;
                    stateNext_s = SERVICE;
                end else if (!any_s) begin
                    stateNext_s = IDLE;
                end else begin
                    stateNext_s = ASSERT;
                end
            end
            SERVICE: begin
                if (irq_done) stateNext_s = IDLE;
                else          stateNext_s = SERVICE;
            end
            default: stateNext_s = IDLE;
        endcase
    end

    // pending update: W1C and ack clear, new edges set and win on overlap
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            selOneHot_s[i] = (sel_s == 3'(i));
        end
        pendClr_s = {NUM_SRC{1'b0}};
        if (pendWe_s) pendClr_s = pendClr_s | bus.wdata[NUM_SRC-1:0];
        else          pendClr_s = pendClr_s;
        if (ackTaken_s) pendClr_s = pendClr_s | (selOneHot_s & active_s);
        else            pendClr_s = pendClr_s;
        pendNext_s = (pend_r & ~pendClr_s) | edge_s;
    end

    // register file, FSM state and the registered IRQ output
    always_ff @(posedge clk) begin
        if (reset) begin
            srcPrev_r    <= {NUM_SRC{1'b0}};
            mask_r       <= {NUM_SRC{1'b0}};
            pend_r       <= {NUM_SRC{1'b0}};
            state_r      <= IDLE;
            causeValid_r <= 1'b0;
            causeIdx_r   <= 3'd0;
            irq_r        <= 1'b0;
        end else begin
            srcPrev_r <= src_irq;
            pend_r    <= pendNext_s;
            state_r   <= stateNext_s;
            irq_r     <= (stateNext_s == ASSERT);
            if (maskWe_s) mask_r <= bus.wdata[NUM_SRC-1:0];
            if (ackTaken_s) begin
                causeValid_r <= 1'b1;
                causeIdx_r   <= sel_s;
            end else if ((state_r == SERVICE) && irq_done) begin
                causeValid_r <= 1'b0;
            end
        end
    end

    // bus read mux, zero unless a mapped register is being read
    always_comb begin
        rdata_s = 32'd0;
        if (bus.mem_read) begin
            if (bus.addr == (BASE_ADDR + MASK_OFS))       rdata_s = 32'(mask_r);
            else if (bus.addr == (BASE_ADDR + PEND_OFS))  rdata_s = 32'(pend_r);
            else if (bus.addr == (BASE_ADDR + CAUSE_OFS)) rdata_s = causeWord(causeValid_r, causeIdx_r);
            else                                          rdata_s = 32'd0;
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.rdata = rdata_s;
    assign IRQ       = irq_r;

endmodule
